vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, giving horizontal front porch, sync and back porch widths in pixels.
REQ-003 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, giving the vertical equivalents in lines.
REQ-004 The block SHALL have parameter CLK_DIV, default 2, giving clk cycles per pixel (legal range 1..15).
REQ-005 The block SHALL have parameter SYNC_POL, default 0, giving the active sync level (0 = active-low).
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port pix_en, output, 1 bit: pixel strobe, high one clk per pixel.
REQ-009 The block SHALL have port hcount, output, 11 bits: current pixel column.
REQ-010 The block SHALL have port vcount, output, 11 bits: current line.
REQ-011 The block SHALL have ports hsync and vsync, outputs, 1 bit each: sync pulses at SYNC_POL level.
REQ-012 The block SHALL have ports hblank, vblank and blank, outputs, 1 bit each: non-visible region flags; blank = hblank OR vblank.
REQ-013 The block SHALL have port frame_start, output, 1 bit: one-clk pulse at pixel (0,0).
REQ-014 The block SHALL have port frame_count, output, 8 bits: completed-frame counter.

Function
REQ-015 A divider SHALL count 0..CLK_DIV-1, wrap to 0, and assert pix_en during the clk in which it equals CLK_DIV-1; with CLK_DIV=1, pix_en SHALL be constantly high out of reset.
REQ-016 hcount SHALL advance only on clk edges where pix_en is high, counting 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 800) and wrapping to 0.
REQ-017 vcount SHALL increment only on the pix_en edge where hcount wraps, counting 0..V_TOTAL-1 (default 525) and wrapping to 0.
REQ-018 Regions SHALL be ordered active, front porch, sync, back porch, giving default horizontal ranges active 0..639, FP 640..655, sync 656..751, BP 752..799.
REQ-019 Regions SHALL give default vertical ranges active 0..479, FP 480..489, sync 490..491, BP 492..524.
REQ-020 hsync, vsync, hblank and vblank SHALL be registered outputs that change on the same clk edge as the hcount/vcount value they describe, with zero relative skew and no glitches; downstream logic edge-triggers on vblank.
REQ-021 hblank SHALL be high iff hcount >= H_ACTIVE, and vblank SHALL be high iff vcount >= V_ACTIVE.
REQ-022 hsync SHALL be at SYNC_POL iff hcount lies in the horizontal sync range, and at ~SYNC_POL otherwise; vsync SHALL follow the same rule on vcount.
REQ-023 vsync SHALL change only at hcount wrap, i.e. at a line boundary.
REQ-024 frame_start SHALL be high for exactly one clk: the clk in which hcount and vcount first both equal 0 after a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-025 frame_start SHALL NOT be asserted after reset until the first full frame has completed.
REQ-026 frame_count SHALL increment on the same edge that frame_start rises, and SHALL wrap from 255 to 0.
REQ-027 All counter comparisons SHALL be full 11-bit unsigned; counts at or above H_TOTAL or V_TOTAL are unreachable.

Reset
REQ-028 While rst_n is low at a clk edge, the block SHALL load divider=0, hcount=0, vcount=0, frame_count=0, pix_en=0, frame_start=0, hblank=0, vblank=0, blank=0, and hsync=vsync=~SYNC_POL.
REQ-029 Reset asserted mid-frame SHALL take effect at the next clk edge regardless of pix_en.
REQ-030 After rst_n goes high, the first pix_en SHALL occur CLK_DIV clk cycles after release, and hcount SHALL become 1 on that edge.

Verification
REQ-031 The bench SHALL cover defaults, reset release, then running 800*525*2 clks -> exactly 420000 pix_en pulses, hcount 0..799 and vcount 0..524 each wrap correctly, and one frame_start at the end with frame_count=1.
REQ-032 The bench SHALL cover checking hsync across one line -> low exactly for hcount 656..751 (96 pixels, 192 clks), high elsewhere; hblank high for hcount 640..799.
REQ-033 The bench SHALL cover checking vsync and vblank over one frame -> vsync low only for vcount 490..491, changing only where hcount=0; vblank rises at the pix_en edge where vcount goes 479->480.
REQ-034 The bench SHALL cover running 256 frames -> frame_count wraps 255->0, and frame_start pulses exactly 256 times, each 1 clk wide.
REQ-035 The bench SHALL cover asserting rst_n low at hcount=400, vcount=300 for 1 clk -> next edge all outputs match REQ-028, and the sequence restarts per REQ-030.
REQ-036 The bench SHALL cover CLK_DIV=1 and SYNC_POL=1 -> pix_en stuck high after reset, a line is 800 clks, and hsync is high only for hcount 656..751.

Source files
------------

// File: rtl/vga_timing_if.sv
// VGA timing output bundle: pixel strobe, raster position, sync/blank flags and frame markers.
// The timing generator drives the master side; display pipelines read through the slave side.
interface vga_timing_if;
   logic        pix_en;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblank;
   logic        vblank;
   logic        blank;
   logic        frame_start;
   logic [7:0]  frame_count;

   modport master (
      output pix_en, hcount, vcount, hsync, vsync,
             hblank, vblank, blank, frame_start, frame_count
   );

   modport slave (
      input  pix_en, hcount, vcount, hsync, vsync,
             hblank, vblank, blank, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: divides clk down to a pixel strobe, walks the raster and
// produces registered sync/blank flags aligned with the counters they describe.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   vga_timing_if.master  vga
);

   localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]  DIV_MAX  = 4'(CLK_DIV - 1);

   logic [3:0]  div;
   logic [3:0]  div_next;
   logic [10:0] h_next;
   logic [10:0] v_next;
   logic        h_wrap;
   logic        v_wrap;

   always_comb begin
      div_next = (div == DIV_MAX) ? 4'd0 : div + 4'd1;
      h_wrap   = (vga.hcount == H_TOTAL - 11'd1);
      v_wrap   = (vga.vcount == V_TOTAL - 11'd1);
      h_next   = h_wrap ? 11'd0 : vga.hcount + 11'd1;
      v_next   = vga.vcount;
      if (h_wrap) begin
         v_next = v_wrap ? 11'd0 : vga.vcount + 11'd1;
      end
   end

   // Flags are decoded from the next counter values so they land on the same edge as the counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div             <= 4'd0;
         vga.pix_en      <= 1'b0;
         vga.hcount      <= 11'd0;
         vga.vcount      <= 11'd0;
         vga.hsync       <= ~SYNC_POL;
         vga.vsync       <= ~SYNC_POL;
         vga.hblank      <= 1'b0;
         vga.vblank      <= 1'b0;
         vga.blank       <= 1'b0;
         vga.frame_start <= 1'b0;
         vga.frame_count <= 8'd0;
      end else begin
         div             <= div_next;
         vga.pix_en      <= (div_next == DIV_MAX);
         vga.frame_start <= 1'b0;
         if (vga.pix_en) begin
            vga.hcount <= h_next;
            vga.vcount <= v_next;
            vga.hblank <= (h_next >= H_ACT);
            vga.vblank <= (v_next >= V_ACT);
            vga.blank  <= (h_next >= H_ACT) || (v_next >= V_ACT);
            vga.hsync  <= ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vga.vsync  <= ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
            if (h_wrap && v_wrap) begin
               vga.frame_start <= 1'b1;
               vga.frame_count <= vga.frame_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default timing, a shrunken raster for frame-level behaviour,
// and a CLK_DIV=1 / positive-sync variant, each checked against a pixel-index model.
module tb_vga_timing;

   logic clk = 1'b0;
   logic rst_d = 1'b0;
   logic rst_s = 1'b0;
   logic rst_p = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   int   kd = 0;

   always #5 clk = ~clk;

   vga_timing_if bus_d ();
   vga_timing_if bus_s ();
   vga_timing_if bus_p ();

   vga_timing dut_d (.clk(clk), .rst_n(rst_d), .vga(bus_d));

   // Tiny raster: 8 pixels x 7 lines, hsync on pixels 5..6, vsync on lines 4..5, 112 clks per frame.
   vga_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(2), .SYNC_POL(1'b0)
   ) dut_s (.clk(clk), .rst_n(rst_s), .vga(bus_s));

   vga_timing #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_p (.clk(clk), .rst_n(rst_p), .vga(bus_p));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_d = 1'b0;
      tick();
      tick();
      compared += 10;
      if (bus_d.pix_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pix_en: got %b expected 0", bus_d.pix_en); end
      if (bus_d.hcount !== 11'd0) begin mismatched++; $display("[TB] FAIL reset_hcount: got %0d expected 0", bus_d.hcount); end
      if (bus_d.vcount !== 11'd0) begin mismatched++; $display("[TB] FAIL reset_vcount: got %0d expected 0", bus_d.vcount); end
      if (bus_d.hsync !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hsync: got %b expected 1", bus_d.hsync); end
      if (bus_d.vsync !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_vsync: got %b expected 1", bus_d.vsync); end
      if (bus_d.hblank !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hblank: got %b expected 0", bus_d.hblank); end
      if (bus_d.vblank !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_vblank: got %b expected 0", bus_d.vblank); end
      if (bus_d.blank !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_blank: got %b expected 0", bus_d.blank); end
      if (bus_d.frame_start !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_start: got %b expected 0", bus_d.frame_start); end
      if (bus_d.frame_count !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_frame_count: got %0d expected 0", bus_d.frame_count); end
   endtask

   // Default timing, CLK_DIV=2: after release edge k the pixel index is k/2 and pix_en is high for odd k.
   task automatic test_line();
      int hs_low_clks = 0;
      rst_d = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         int p = k / 2;
         int eh = p % 800;
         int ev = p / 800;
         logic ehs = !((eh >= 656) && (eh <= 751));
         logic ehb = (eh >= 640);
         tick();
         kd = k;
         if (ev == 0 && bus_d.hsync === 1'b0) hs_low_clks++;
         compared += 6;
         if (bus_d.pix_en !== (k % 2 == 1)) begin mismatched++; $display("[TB] FAIL line_pix_en k=%0d: got %b expected %b", k, bus_d.pix_en, (k % 2 == 1)); end
         if (bus_d.hcount !== 11'(eh)) begin mismatched++; $display("[TB] FAIL line_hcount k=%0d: got %0d expected %0d", k, bus_d.hcount, eh); end
         if (bus_d.vcount !== 11'(ev)) begin mismatched++; $display("[TB] FAIL line_vcount k=%0d: got %0d expected %0d", k, bus_d.vcount, ev); end
         if (bus_d.hsync !== ehs) begin mismatched++; $display("[TB] FAIL line_hsync k=%0d h=%0d: got %b expected %b", k, eh, bus_d.hsync, ehs); end
         if (bus_d.hblank !== ehb) begin mismatched++; $display("[TB] FAIL line_hblank k=%0d h=%0d: got %b expected %b", k, eh, bus_d.hblank, ehb); end
         if (bus_d.blank !== ehb) begin mismatched++; $display("[TB] FAIL line_blank k=%0d h=%0d: got %b expected %b", k, eh, bus_d.blank, ehb); end
      end
      compared++;
      if (hs_low_clks != 192) begin mismatched++; $display("[TB] FAIL line_hsync_width: got %0d clks expected 192", hs_low_clks); end
   endtask

   // Runs on to pixel (400,1) with pix_en high, then pulses reset for one clk and checks the restart.
   task automatic test_mid_reset();
      while (kd < 2401) begin
         tick();
         kd++;
      end
      compared += 3;
      if (bus_d.hcount !== 11'd400) begin mismatched++; $display("[TB] FAIL mid_pre_hcount: got %0d expected 400", bus_d.hcount); end
      if (bus_d.vcount !== 11'd1) begin mismatched++; $display("[TB] FAIL mid_pre_vcount: got %0d expected 1", bus_d.vcount); end
      if (bus_d.pix_en !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pre_pix_en: got %b expected 1", bus_d.pix_en); end
      rst_d = 1'b0;
      tick();
      rst_d = 1'b1;
      compared += 6;
      if (bus_d.hcount !== 11'd0) begin mismatched++; $display("[TB] FAIL mid_hcount: got %0d expected 0", bus_d.hcount); end
      if (bus_d.vcount !== 11'd0) begin mismatched++; $display("[TB] FAIL mid_vcount: got %0d expected 0", bus_d.vcount); end
      if (bus_d.pix_en !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_pix_en: got %b expected 0", bus_d.pix_en); end
      if (bus_d.hsync !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_hsync: got %b expected 1", bus_d.hsync); end
      if (bus_d.blank !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_blank: got %b expected 0", bus_d.blank); end
      if (bus_d.frame_count !== 8'd0) begin mismatched++; $display("[TB] FAIL mid_frame_count: got %0d expected 0", bus_d.frame_count); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         compared += 2;
         if (bus_d.pix_en !== (k % 2 == 1)) begin mismatched++; $display("[TB] FAIL restart_pix_en k=%0d: got %b expected %b", k, bus_d.pix_en, (k % 2 == 1)); end
         if (bus_d.hcount !== 11'(k / 2)) begin mismatched++; $display("[TB] FAIL restart_hcount k=%0d: got %0d expected %0d", k, bus_d.hcount, k / 2); end
      end
   endtask

   // Small raster: one complete frame with full region checks, then on through 256 frames.
   task automatic test_frames();
      int pix_pulses = 0;
      int fs_pulses = 0;
      logic prev_vsync = 1'b1;
      logic prev_vblank = 1'b0;
      logic prev_fs = 1'b0;
      rst_s = 1'b0;
      tick();
      rst_s = 1'b1;
      for (int k = 1; k <= 256 * 112; k++) begin
         int p = k / 2;
         int eh = p % 8;
         int ev = (p / 8) % 7;
         logic efs = (k % 2 == 0) && (p % 56 == 0) && (p > 0);
         tick();
         if (bus_s.pix_en === 1'b1) pix_pulses++;
         if (bus_s.frame_start === 1'b1) fs_pulses++;
         compared += 2;
         if (bus_s.frame_start !== efs) begin mismatched++; $display("[TB] FAIL frame_start k=%0d: got %b expected %b", k, bus_s.frame_start, efs); end
         if (bus_s.frame_count !== 8'((p / 56) % 256)) begin mismatched++; $display("[TB] FAIL frame_count k=%0d: got %0d expected %0d", k, bus_s.frame_count, (p / 56) % 256); end
         if (prev_fs === 1'b1) begin
            compared++;
            if (bus_s.frame_start !== 1'b0) begin mismatched++; $display("[TB] FAIL frame_start_width k=%0d: got %b expected 0", k, bus_s.frame_start); end
         end
         prev_fs = bus_s.frame_start;
         if (k <= 112) begin
            logic ehs = !((eh >= 5) && (eh <= 6));
            logic evs = !((ev >= 4) && (ev <= 5));
            compared += 6;
            if (bus_s.hcount !== 11'(eh)) begin mismatched++; $display("[TB] FAIL small_hcount k=%0d: got %0d expected %0d", k, bus_s.hcount, eh); end
            if (bus_s.vcount !== 11'(ev)) begin mismatched++; $display("[TB] FAIL small_vcount k=%0d: got %0d expected %0d", k, bus_s.vcount, ev); end
            if (bus_s.hsync !== ehs) begin mismatched++; $display("[TB] FAIL small_hsync k=%0d: got %b expected %b", k, bus_s.hsync, ehs); end
            if (bus_s.vsync !== evs) begin mismatched++; $display("[TB] FAIL small_vsync k=%0d: got %b expected %b", k, bus_s.vsync, evs); end
            if (bus_s.vblank !== (ev >= 3)) begin mismatched++; $display("[TB] FAIL small_vblank k=%0d: got %b expected %b", k, bus_s.vblank, (ev >= 3)); end
            if (bus_s.blank !== ((eh >= 4) || (ev >= 3))) begin mismatched++; $display("[TB] FAIL small_blank k=%0d: got %b expected %b", k, bus_s.blank, ((eh >= 4) || (ev >= 3))); end
            if (bus_s.vsync !== prev_vsync) begin
               compared++;
               if (bus_s.hcount !== 11'd0) begin mismatched++; $display("[TB] FAIL vsync_edge_pos k=%0d: got hcount %0d expected 0", k, bus_s.hcount); end
            end
            if (prev_vblank === 1'b0 && bus_s.vblank === 1'b1) begin
               compared++;
               if (bus_s.vcount !== 11'd3 || k % 2 != 0) begin mismatched++; $display("[TB] FAIL vblank_rise k=%0d: got vcount %0d expected 3 on a pixel edge", k, bus_s.vcount); end
            end
            prev_vsync = bus_s.vsync;
            prev_vblank = bus_s.vblank;
         end
         if (k == 112) begin
            compared += 3;
            if (pix_pulses != 56) begin mismatched++; $display("[TB] FAIL one_frame_pix_en: got %0d expected 56", pix_pulses); end
            if (fs_pulses != 1) begin mismatched++; $display("[TB] FAIL one_frame_starts: got %0d expected 1", fs_pulses); end
            if (bus_s.frame_count !== 8'd1) begin mismatched++; $display("[TB] FAIL one_frame_count: got %0d expected 1", bus_s.frame_count); end
         end
      end
      compared += 2;
      if (fs_pulses != 256) begin mismatched++; $display("[TB] FAIL frame_start_total: got %0d expected 256", fs_pulses); end
      if (bus_s.frame_count !== 8'd0) begin mismatched++; $display("[TB] FAIL frame_count_wrap: got %0d expected 0", bus_s.frame_count); end
   endtask

   // CLK_DIV=1 with positive sync: the first edge only raises pix_en, pixels advance from edge 2 on.
   task automatic test_clkdiv1_pol();
      int hs_high = 0;
      int last_wrap = -1;
      int line_len = 0;
      logic [10:0] prev_h = 11'd0;
      rst_p = 1'b0;
      tick();
      compared += 3;
      if (bus_p.pix_en !== 1'b0) begin mismatched++; $display("[TB] FAIL pol_reset_pix_en: got %b expected 0", bus_p.pix_en); end
      if (bus_p.hsync !== 1'b0) begin mismatched++; $display("[TB] FAIL pol_reset_hsync: got %b expected 0", bus_p.hsync); end
      if (bus_p.vsync !== 1'b0) begin mismatched++; $display("[TB] FAIL pol_reset_vsync: got %b expected 0", bus_p.vsync); end
      rst_p = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         int eh = (k - 1) % 800;
         logic ehs = (eh >= 656) && (eh <= 751);
         tick();
         if (k <= 800 && bus_p.hsync === 1'b1) hs_high++;
         if (prev_h == 11'd799 && bus_p.hcount == 11'd0) begin
            if (last_wrap >= 0) line_len = k - last_wrap;
            last_wrap = k;
         end
         prev_h = bus_p.hcount;
         compared += 3;
         if (bus_p.pix_en !== 1'b1) begin mismatched++; $display("[TB] FAIL pol_pix_en k=%0d: got %b expected 1", k, bus_p.pix_en); end
         if (bus_p.hcount !== 11'(eh)) begin mismatched++; $display("[TB] FAIL pol_hcount k=%0d: got %0d expected %0d", k, bus_p.hcount, eh); end
         if (bus_p.hsync !== ehs) begin mismatched++; $display("[TB] FAIL pol_hsync k=%0d: got %b expected %b", k, bus_p.hsync, ehs); end
      end
      compared += 2;
      if (hs_high != 96) begin mismatched++; $display("[TB] FAIL pol_hsync_width: got %0d expected 96", hs_high); end
      if (line_len != 800) begin mismatched++; $display("[TB] FAIL pol_line_length: got %0d expected 800", line_len); end
   endtask

   initial begin
      $display("[TB] vga_timing bench start");
      test_reset();
      test_line();
      test_mid_reset();
      test_frames();
      test_clkdiv1_pol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
